sys_clkgen_div: RTL and testbench

Parametrised multi-channel clock generator derived from a single reference clock, for SDRAM/system clocking where a vendor PLL is unavailable or extra derived clocks are needed. Each channel produces a registered clock at refclk/DIV with a programmable phase offset in whole refclk cycles. All channels restart together after reset or reconfiguration, so their relative phase is deterministic. A `locked` flag asserts once outputs have run stable for a programmable interval.

---
 rtl/sys_clkgen_div.sv | 166 ++++++++++++++++
 tb/tb_sys_clkgen_div.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sys_clkgen_div.sv
// Multi-channel divided clock generator running from a single reference clock.
// Every channel produces refclk/DIV with a whole-cycle phase delay. All channels
// restart together after reset or after any accepted reconfiguration, so their
// relative phase is always deterministic. `locked` follows a fixed settle time.
module sys_clkgen_div #(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*CNT_WIDTH-1:0] DEFAULT_DIV   = {NUM_CLOCKS{8'd4}},
  parameter logic [NUM_CLOCKS*CNT_WIDTH-1:0] DEFAULT_PHASE = {8'd1, 8'd0},
  localparam int CHAN_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [CNT_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCK_W-1:0]  LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);
  localparam logic [CHAN_W:0]   NUM_CH    = (CHAN_W + 1)'(NUM_CLOCKS);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Divide ratios below 2 cannot produce a clock; force the minimum.
  function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] d);
    return (d < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : d;
  endfunction

  // A phase of a full period or more is meaningless; saturate to div-1.
  function automatic logic [CNT_WIDTH-1:0] clamp_phase(input logic [CNT_WIDTH-1:0] p,
                                                       input logic [CNT_WIDTH-1:0] d);
    return (p >= d) ? (d - 1'b1) : p;
  endfunction

  state_e               state_q, state_d;
  logic [LCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                 cfg_ready_q;
  logic                 locked_q;
  logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0] tick_q, tick_d;

  logic [CNT_WIDTH-1:0] div_q [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] ph_q  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] dly_q [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] dly_d [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CLOCKS];

  logic                 cfg_acc;
  logic                 cfg_hit;
  logic                 run_d;
  logic [CNT_WIDTH-1:0] new_div;
  logic [CNT_WIDTH-1:0] new_ph;

  // An out-of-range channel is acknowledged but neither writes nor restarts.
  assign cfg_acc = cfg_valid && cfg_ready_q;
  assign cfg_hit = cfg_acc && ({1'b0, cfg_chan} < NUM_CH);
  assign new_div = clamp_div(cfg_div);
  assign new_ph  = clamp_phase(cfg_phase, new_div);
  assign run_d   = (state_d != ST_START);

  // Sequencing: START -> SETTLE -> LOCKED; any effective write forces START.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_START: begin
        state_d    = ST_SETTLE;
        lock_cnt_d = '0;
      end
      ST_SETTLE: begin
        if (lock_cnt_q == LOCK_LAST) state_d = ST_LOCKED;
        else                         lock_cnt_d = lock_cnt_q + 1'b1;
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_START;
    endcase
    if (cfg_hit) state_d = ST_START;
  end

  // FSM, lock counter and registered status outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      lock_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      cfg_ready_q <= (state_d != ST_START);
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

  // Shadow divide/phase registers, clamped on write.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i] <= clamp_div(DEFAULT_DIV[i*CNT_WIDTH +: CNT_WIDTH]);
        ph_q[i]  <= clamp_phase(DEFAULT_PHASE[i*CNT_WIDTH +: CNT_WIDTH],
                                clamp_div(DEFAULT_DIV[i*CNT_WIDTH +: CNT_WIDTH]));
      end
    end else if (cfg_hit) begin
      div_q[cfg_chan] <= new_div;
      ph_q[cfg_chan]  <= new_ph;
    end
  end

  // Channel position for the next cycle: phase delay first, then 0..div-1.
  // Outputs are decoded from the next position so they come straight off flops.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      dly_d[i] = dly_q[i];
      cnt_d[i] = cnt_q[i];
      if (state_q == ST_START) begin
        dly_d[i] = ph_q[i];
        cnt_d[i] = '0;
      end else if (dly_q[i] != '0) begin
        dly_d[i] = dly_q[i] - 1'b1;
      end else if (cnt_q[i] == (div_q[i] - 1'b1)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      outclk_d[i] = run_d && (dly_d[i] == '0) && (cnt_d[i] < (div_q[i] >> 1));
      tick_d[i]   = run_d && (dly_d[i] == '0) && (cnt_d[i] == '0);
    end
  end

  // Channel counters and generated clock/tick registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        dly_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      outclk_q <= '0;
      tick_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        dly_q[i] <= dly_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;
  assign outclk    = outclk_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_sys_clkgen_div.sv
// Scoreboard bench for sys_clkgen_div. A three-channel build is used so that a
// 2-bit channel field can address a non-existent channel (3).
module tb_sys_clkgen_div;

  localparam int NCH = 3;
  localparam int LCK = 16;

  logic           refclk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_chan;
  logic [7:0]     cfg_div;
  logic [7:0]     cfg_phase;
  logic [NCH-1:0] outclk;
  logic [NCH-1:0] tick;
  logic           locked;

  sys_clkgen_div #(
    .NUM_CLOCKS   (NCH),
    .CNT_WIDTH    (8),
    .LOCK_CYCLES  (LCK),
    .DEFAULT_DIV  ({8'd6, 8'd4, 8'd4}),
    .DEFAULT_PHASE({8'd3, 8'd1, 8'd0})
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .tick     (tick),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tk;
    logic           lk;
    logic           rdy;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: shadow settings plus "in START" / SETTLE cycle index.
  int   m_div[NCH];
  int   m_ph[NCH];
  bit   m_start;
  int   m_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_div[0] = 4; m_ph[0] = 0;
    m_div[1] = 4; m_ph[1] = 1;
    m_div[2] = 6; m_ph[2] = 3;
    m_start  = 1'b1;
    m_s      = 0;
  endtask

  // Advance the model across one refclk edge and queue the outputs it predicts.
  task automatic model_edge(input logic v, input logic [1:0] ch,
                            input logic [7:0] d, input logic [7:0] p);
    exp_t e;
    int   dd, pp, k;
    if (v && !m_start && (int'(ch) < NCH)) begin
      dd = (int'(d) < 2) ? 2 : int'(d);
      pp = (int'(p) >= dd) ? dd - 1 : int'(p);
      m_div[ch] = dd;
      m_ph[ch]  = pp;
      m_start   = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0;
      m_s     = 0;
    end else begin
      m_s++;
    end
    e = '0;
    if (!m_start) begin
      e.rdy = 1'b1;
      e.lk  = (m_s >= LCK);
      for (int i = 0; i < NCH; i++) begin
        if (m_s >= m_ph[i]) begin
          k = (m_s - m_ph[i]) % m_div[i];
          e.clk[i] = (k < m_div[i] / 2);
          e.tk[i]  = (k == 0);
        end
      end
    end
    sb.push_back(e);
  endtask

  // One refclk cycle: drive request, predict at the edge, compare just after.
  task automatic cyc(input logic v, input logic [1:0] ch,
                     input logic [7:0] d, input logic [7:0] p);
    exp_t e;
    cfg_valid = v;
    cfg_chan  = ch;
    cfg_div   = d;
    cfg_phase = p;
    @(posedge refclk);
    model_edge(v, ch, d, p);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("outclk",    32'(outclk),    32'(e.clk));
      chk("tick",      32'(tick),      32'(e.tk));
      chk("locked",    32'(locked),    32'(e.lk));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outclk"}, 32'(outclk),    32'd0);
    chk({tag, "_tick"},   32'(tick),      32'd0);
    chk({tag, "_locked"}, 32'(locked),    32'd0);
    chk({tag, "_ready"},  32'(cfg_ready), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    model_reset();

    repeat (2) @(posedge refclk);
    #1;
    check_all_zero("rst");
    @(negedge refclk);
    rst_n = 1'b1;

    // Default sequence up to and past lock.
    idle(24);

    // Channel 0 -> div 5, phase 2 while locked.
    cyc(1'b1, 2'd0, 8'd5, 8'd2);
    idle(24);

    // Channel 1 -> div 0, phase 9: clamps to div 2, phase 1.
    cyc(1'b1, 2'd1, 8'd0, 8'd9);
    idle(20);

    // Non-existent channel: acknowledged, no restart, no effect.
    cyc(1'b1, 2'd3, 8'd7, 8'd1);
    idle(6);

    // Request held for three cycles: accept, blocked in START, accept again.
    cyc(1'b1, 2'd0, 8'd3, 8'd0);
    cyc(1'b1, 2'd0, 8'd3, 8'd0);
    cyc(1'b1, 2'd0, 8'd3, 8'd0);
    idle(22);

    // Restart, then reset asynchronously part way through SETTLE.
    cyc(1'b1, 2'd2, 8'd6, 8'd0);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    idle(24);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
